// File: rtl/tpu_sram_loader.sv
// tpu_sram_loader
//   Upstream stage of the TPU core. Fills the four input SRAM banks (w0, w1, d0, d1)
//   from a host word stream, then fires a one-cycle start pulse to the core and stays
//   busy until the core reports done.
//
// Ports
//   clk                   rising-edge clock
//   srst                  synchronous reset, active-high, overrides every other input
//   load_start            begin a load+compute run (only looked at in IDLE)
//   in_valid / in_data    host word stream
//   in_ready              loader accepts a word this cycle (high in the LOAD states only)
//   sram_write_enable_*   registered per-bank write strobes, at most one high per cycle
//   sram_waddr            registered write address, shared by all banks
//   sram_wdata            registered write data, shared by all banks
//   tpu_start             one-cycle start pulse, the cycle after the final d1 write
//   tpu_done              core completion flag, looked at in WAIT only
//   busy                  high in every state except IDLE
//   load_done             one-cycle pulse while in DONE
module tpu_sram_loader #(
  parameter int unsigned SRAM_DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned WORDS_PER_BANK  = 256
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       load_start,
  input  logic                       in_valid,
  input  logic [SRAM_DATA_WIDTH-1:0] in_data,
  output logic                       in_ready,
  output logic                       sram_write_enable_w0,
  output logic                       sram_write_enable_w1,
  output logic                       sram_write_enable_d0,
  output logic                       sram_write_enable_d1,
  output logic [ADDR_WIDTH-1:0]      sram_waddr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wdata,
  output logic                       tpu_start,
  input  logic                       tpu_done,
  output logic                       busy,
  output logic                       load_done
);

  // One extra counter bit so that WORDS_PER_BANK = 2**ADDR_WIDTH is representable.
  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WORDS_PER_BANK - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW0,
    StLoadW1,
    StLoadD0,
    StLoadD1,
    StStart,
    StWait,
    StDone
  } state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [3:0]                 we_q, we_d;      // {d1, d0, w1, w0}
  logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
  logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                       start_q, start_d;
  logic                       done_q, done_d;

  logic                       loading;
  logic                       accept;
  logic                       last_word;
  logic [3:0]                 bank_sel;
  state_e                     bank_next;

  always_comb begin
    loading   = (state_q == StLoadW0) || (state_q == StLoadW1) ||
                (state_q == StLoadD0) || (state_q == StLoadD1);
    accept    = loading && in_valid;
    last_word = (cnt_q == LastIdx);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = '0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    bank_sel  = '0;
    bank_next = StIdle;

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d = StLoadW0;
          cnt_d   = '0;
        end
      end
      StLoadW0: begin
        bank_sel  = 4'b0001;
        bank_next = StLoadW1;
      end
      StLoadW1: begin
        bank_sel  = 4'b0010;
        bank_next = StLoadD0;
      end
      StLoadD0: begin
        bank_sel  = 4'b0100;
        bank_next = StLoadD1;
      end
      StLoadD1: begin
        bank_sel  = 4'b1000;
        bank_next = StStart;
      end
      StStart: begin
        start_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // done_q rises together with the DONE state, so load_done overlaps busy=1.
        if (tpu_done) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase

    // The strobe is computed from the current bank, so the last word of a bank still lands
    // in that bank even though the state moves on in the same edge.
    if (accept) begin
      we_d    = bank_sel;
      waddr_d = cnt_q[ADDR_WIDTH-1:0];
      wdata_d = in_data;
      if (last_word) begin
        cnt_d   = '0;
        state_d = bank_next;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign in_ready             = loading;
  assign sram_write_enable_w0 = we_q[0];
  assign sram_write_enable_w1 = we_q[1];
  assign sram_write_enable_d0 = we_q[2];
  assign sram_write_enable_d1 = we_q[3];
  assign sram_waddr           = waddr_q;
  assign sram_wdata           = wdata_q;
  assign tpu_start            = start_q;
  assign load_done            = done_q;
  assign busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_tpu_sram_loader.sv
// Testbench for tpu_sram_loader. Two instances: a 4-word-per-bank loader for the
// functional runs and a 1024-word-per-bank loader for the full-address-range run.
// Expected bank writes and pulses are queued with the cycle they must appear in;
// a negedge monitor pops and compares whatever the loaders present.
module tb_tpu_sram_loader;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 10;
  localparam int unsigned Wpb0 = 4;
  localparam int unsigned Wpb1 = 1024;

  // kind: 0..3 = write to w0,w1,d0,d1; 4 = tpu_start; 5 = load_done
  typedef struct packed {
    logic [3:0]  kind;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic [31:0]   cyc = '0;
  logic          srst       [2];
  logic          load_start [2];
  logic          in_valid   [2];
  logic [DW-1:0] in_data    [2];
  logic          tpu_done   [2];
  logic          ready      [2];
  logic [3:0]    we         [2];
  logic [AW-1:0] waddr      [2];
  logic [DW-1:0] wdata      [2];
  logic          start      [2];
  logic          busy       [2];
  logic          ldone      [2];

  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  ev_t sb0[$];
  ev_t sb1[$];

  tpu_sram_loader #(
    .SRAM_DATA_WIDTH(DW),
    .ADDR_WIDTH     (AW),
    .WORDS_PER_BANK (Wpb0)
  ) u_dut0 (
    .clk                 (clk),
    .srst                (srst[0]),
    .load_start          (load_start[0]),
    .in_valid            (in_valid[0]),
    .in_data             (in_data[0]),
    .in_ready            (ready[0]),
    .sram_write_enable_w0(we[0][0]),
    .sram_write_enable_w1(we[0][1]),
    .sram_write_enable_d0(we[0][2]),
    .sram_write_enable_d1(we[0][3]),
    .sram_waddr          (waddr[0]),
    .sram_wdata          (wdata[0]),
    .tpu_start           (start[0]),
    .tpu_done            (tpu_done[0]),
    .busy                (busy[0]),
    .load_done           (ldone[0])
  );

  tpu_sram_loader #(
    .SRAM_DATA_WIDTH(DW),
    .ADDR_WIDTH     (AW),
    .WORDS_PER_BANK (Wpb1)
  ) u_dut1 (
    .clk                 (clk),
    .srst                (srst[1]),
    .load_start          (load_start[1]),
    .in_valid            (in_valid[1]),
    .in_data             (in_data[1]),
    .in_ready            (ready[1]),
    .sram_write_enable_w0(we[1][0]),
    .sram_write_enable_w1(we[1][1]),
    .sram_write_enable_d0(we[1][2]),
    .sram_write_enable_d1(we[1][3]),
    .sram_waddr          (waddr[1]),
    .sram_wdata          (wdata[1]),
    .tpu_start           (start[1]),
    .tpu_done            (tpu_done[1]),
    .busy                (busy[1]),
    .load_done           (ldone[1])
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [3:0] kind, input logic [9:0] addr,
                      input logic [31:0] data, input logic [31:0] c);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic pop_cmp(input int d, input logic [3:0] kind, input logic [9:0] addr,
                         input logic [31:0] data);
    ev_t e;
    int  n;
    n = (d == 0) ? sb0.size() : sb1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d @cyc %0d: actual kind=%0d addr=%0h data=%0h required none",
               d, cyc, kind, addr, data);
    end else begin
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_addr_data", {22'd0, addr, data}, {22'd0, e.addr, e.data});
      chk("event_cycle", 64'(cyc), 64'(e.cyc));
    end
  endtask

  function automatic logic [3:0] we_kind(input logic [3:0] w);
    if (w[0])      return 4'd0;
    else if (w[1]) return 4'd1;
    else if (w[2]) return 4'd2;
    else           return 4'd3;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (|we[d]) begin
          chk("single_enable", 64'($countones(we[d])), 64'd1);
          pop_cmp(d, we_kind(we[d]), waddr[d], wdata[d]);
        end
        if (start[d]) pop_cmp(d, 4'd4, '0, '0);
        if (ldone[d]) pop_cmp(d, 4'd5, '0, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int d);
    chk("reset_outputs",
        64'({we[d], waddr[d], wdata[d], start[d], ldone[d], busy[d], ready[d]}), 64'd0);
  endtask

  // mode 0: valid every cycle, data 1,2,3..; mode 1: valid 1,0,0 repeating; mode 2: random
  task automatic run(input int d, input int wpb, input int mode, input int wait_cycles);
    int          sent;
    int          phase;
    logic        v;
    logic [31:0] data;
    load_start[d] = 1'b1;
    step();
    load_start[d] = 1'b0;
    sent  = 0;
    phase = 0;
    while (sent < 4 * wpb) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (phase % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase++;
      data = (mode == 0) ? 32'(sent + 1) : $urandom;
      in_valid[d] = v;
      in_data[d]  = data;
      tpu_done[d] = (sent == wpb + 1);  // spurious done while loading w1
      chk("in_ready_loading", 64'(ready[d]), 64'd1);
      chk("busy_loading", 64'(busy[d]), 64'd1);
      if (v) push(d, 4'(sent / wpb), 10'(sent % wpb), data, cyc + 1);
      step();
      if (v) sent++;
    end
    // Keep offering words after the last one: none may be accepted.
    in_valid[d] = 1'b1;
    in_data[d]  = $urandom;
    tpu_done[d] = 1'b0;
    chk("in_ready_start", 64'(ready[d]), 64'd0);
    push(d, 4'd4, '0, '0, cyc + 1);
    step();
    in_valid[d] = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      chk("busy_wait", 64'(busy[d]), 64'd1);
      chk("in_ready_wait", 64'(ready[d]), 64'd0);
      step();
    end
    tpu_done[d] = 1'b1;
    push(d, 4'd5, '0, '0, cyc + 1);
    step();
    tpu_done[d]   = 1'b0;
    load_start[d] = 1'b1;  // coincides with load_done, must be ignored
    chk("busy_in_done", 64'(busy[d]), 64'd1);
    step();
    load_start[d] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_after_run", 64'({busy[d], ready[d]}), 64'd0);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      srst[d]       = 1'b1;
      load_start[d] = 1'b1;
      in_valid[d]   = 1'b1;
      in_data[d]    = 32'hdead_beef;
      tpu_done[d]   = 1'b0;
    end
    repeat (3) begin
      step();
      mon_en = 1'b1;
      for (int d = 0; d < 2; d++) check_zero(d);
    end
    for (int d = 0; d < 2; d++) begin
      srst[d]       = 1'b0;
      load_start[d] = 1'b0;
      in_valid[d]   = 1'b0;
    end
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) check_zero(d);
    end

    run(0, Wpb0, 0, 50);
    run(0, Wpb0, 1, 3);

    // Abandon a run after six accepts (w1, counter 2), then restart from w0 addr 0.
    load_start[0] = 1'b1;
    step();
    load_start[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] data;
      data        = $urandom;
      in_valid[0] = 1'b1;
      in_data[0]  = data;
      push(0, 4'(i / Wpb0), 10'(i % Wpb0), data, cyc + 1);
      step();
    end
    in_valid[0] = 1'b0;
    srst[0]     = 1'b1;
    step();
    srst[0] = 1'b0;
    check_zero(0);
    chk("queue_after_reset", 64'(sb0.size()), 64'd0);

    run(0, Wpb0, 2, 7);
    run(1, Wpb1, 2, 2);

    step();
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
